// File: rtl/lut_pkg.sv
// Shared types and sizing helpers for the serially programmed K-input LUT.
package lut_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } lut_state_t;

  localparam int K_MIN = 1;
  localparam int K_MAX = 8;

  // Table depth in bits for a K-input function.
  function automatic int lut_depth(input int k);
    return 1 << k;
  endfunction

  // Load counter width: one extra bit so the count can pass the last entry.
  function automatic int lut_cnt_w(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// Configuration sequencer: owns the LUT state, the serial load counter and the table write strobe.
module lut_cfg_loader
  import lut_pkg::*;
#(
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output lut_state_t       state,
  output logic [K-1:0]     wr_addr,
  output logic             wr_en,
  output logic             cfg_busy,
  output logic             cfg_done
);

  localparam int CNT_W = lut_cnt_w(K);
  localparam int DEPTH = lut_depth(K);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNCFG;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        UNCFG: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          // A restart wins over a coincident data bit.
          if (cfg_start) begin
            cnt <= '0;
          end else if (cfg_valid) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state    <= READY;
              cfg_done <= 1'b1;
            end
          end
        end
        READY: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        default: state <= UNCFG;
      endcase
    end
  end

  assign cfg_busy = (state == LOAD);
  assign wr_en    = (state == LOAD) && cfg_valid && !cfg_start;
  assign wr_addr  = cnt[K-1:0];

endmodule

// File: rtl/cfg_lut_k.sv
// K-input look-up table with a bit-serial programmable truth table and a registered valid/ready lookup.
module cfg_lut_k
  import lut_pkg::*;
#(
  parameter int                 K    = 4,
  parameter logic [(1<<K)-1:0]  INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_busy,
  output logic         cfg_done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] address,
  output logic         out_valid,
  output logic         result
);

  localparam int DEPTH = lut_depth(K);

  lut_state_t       state;
  logic [K-1:0]     wr_addr;
  logic             wr_en;
  logic             accept;
  logic [DEPTH-1:0] tbl;
  logic             vld_p1;
  logic             res_p1;

  lut_cfg_loader #(.K(K)) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .state     (state),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );

  assign in_ready = (state == READY);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl <= INIT;
    end else if (wr_en) begin
      tbl[wr_addr] <= cfg_bit;
    end
  end

  // Stage p1: registered lookup; reads the table as it stood when the request was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      res_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        res_p1 <= tbl[address];
      end
    end
  end

  assign out_valid = vld_p1;
  assign result    = res_p1;

endmodule

// File: tb/tb_cfg_lut_k.sv
// Self-checking bench for cfg_lut_k: K=4 and K=2 instances, scoreboard on lookups plus directed load corner cases.
module tb_cfg_lut_k;

  logic       clk = 1'b0;
  logic       rst;
  logic       c4_start, c4_valid, c4_bit, iv4;
  logic [3:0] addr4;
  logic       busy4, done4, rdy4, ov4, res4;
  logic       c2_start, c2_valid, c2_bit, iv2;
  logic [1:0] addr2;
  logic       busy2, done2, rdy2, ov2, res2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov4_cnt = 0, ov2_cnt = 0;
  int done4_cnt = 0, done2_cnt = 0;
  int done4_cyc = 0;
  int ld_start = 0, ld_first = 0;
  logic [15:0] exp4;
  logic [3:0]  exp2;
  logic        q4[$];
  logic        q2[$];

  typedef struct {
    logic [3:0] addr;
    logic       exp;
  } vec_t;
  vec_t vt[8];

  cfg_lut_k #(.K(4), .INIT(16'h1234)) dut4 (
    .clk(clk), .rst(rst), .cfg_start(c4_start), .cfg_valid(c4_valid), .cfg_bit(c4_bit),
    .cfg_busy(busy4), .cfg_done(done4), .in_valid(iv4), .in_ready(rdy4),
    .address(addr4), .out_valid(ov4), .result(res4)
  );

  cfg_lut_k #(.K(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_start(c2_start), .cfg_valid(c2_valid), .cfg_bit(c2_bit),
    .cfg_busy(busy2), .cfg_done(done2), .in_valid(iv2), .in_ready(rdy2),
    .address(addr2), .out_valid(ov2), .result(res2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: result pops before the same-cycle push, since out_valid now belongs to an older accept.
  task automatic monitor();
    if (rst) begin
      q4.delete();
      q2.delete();
    end else begin
      if (ov4) begin
        ov4_cnt++;
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb4_unexpected: got out_valid result %0b, required no output", res4);
        end else chk("sb4_result", res4, q4.pop_front());
      end
      if (iv4 && rdy4) q4.push_back(exp4[addr4]);
      if (done4) begin done4_cnt++; done4_cyc = cyc; end
      if (ov2) begin
        ov2_cnt++;
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb2_unexpected: got out_valid result %0b, required no output", res2);
        end else chk("sb2_result", res2, q2.pop_front());
      end
      if (iv2 && rdy2) q2.push_back(exp2[addr2]);
      if (done2) done2_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic logic eqf(input logic [3:0] x);
    logic a, b, c, d;
    {d, c, b, a} = x;
    return ~(((a & b & c & d) | (c ^ a)) ^ d);
  endfunction

  task automatic load4(input logic [15:0] pat, input bit gap, input bit do_start, input bit hold_iv);
    int n0;
    n0 = done4_cnt;
    if (do_start) begin
      ld_start = cyc;
      c4_start = 1'b1;
      tick();
      c4_start = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 0) ld_first = cyc;
      c4_valid = 1'b1;
      c4_bit   = pat[i];
      if (hold_iv) iv4 = (i != 15);
      tick();
      if (i != 15) begin
        chk("busy_load", busy4, 1);
        chk("rdy_load", rdy4, 0);
      end
      if (gap) begin
        c4_valid = 1'b0;
        tick();
        if (i != 15) chk("busy_gap", busy4, 1);
      end
    end
    c4_valid = 1'b0;
    tick();
    chk("done_once", done4_cnt - n0, 1);
    chk("done_pulse", done4, 0);
    chk("rdy_after", rdy4, 1);
  endtask

  task automatic sweep4();
    int n0;
    n0 = ov4_cnt;
    for (int a = 0; a < 16; a++) begin
      iv4   = 1'b1;
      addr4 = a[3:0];
      tick();
      chk("sweep_ov", ov4, 1);
    end
    iv4 = 1'b0;
    tick();
    chk("sweep_ov_end", ov4, 0);
    tick();
    chk("sweep_cnt", ov4_cnt - n0, 16);
    chk("sb4_empty", q4.size(), 0);
  endtask

  initial begin
    logic [15:0] p1, p2, p4a, p4b, p5, p6;
    logic [3:0]  pk2;
    int n0;
    p1 = 16'h8000; p2 = 16'hDAA5; p4a = 16'h3C5A; p4b = 16'h96E1;
    p5 = 16'hF00F; p6 = 16'h0FF0; pk2 = 4'b1000;
    vt[0] = '{4'd0, 1'b1};  vt[1] = '{4'd1, 1'b0};
    vt[2] = '{4'd2, 1'b1};  vt[3] = '{4'd3, 1'b0};
    vt[4] = '{4'd5, 1'b1};  vt[5] = '{4'd9, 1'b1};
    vt[6] = '{4'd13, 1'b0}; vt[7] = '{4'd15, 1'b1};

    rst = 1'b1;
    c4_start = 0; c4_valid = 0; c4_bit = 0; iv4 = 0; addr4 = '0;
    c2_start = 0; c2_valid = 0; c2_bit = 0; iv2 = 0; addr2 = '0;
    exp4 = '0; exp2 = '0;
    tick(); tick();
    chk("rst_busy", busy4, 0);  chk("rst_done", done4, 0);
    chk("rst_rdy", rdy4, 0);    chk("rst_ov", ov4, 0);
    chk("rst_res", res4, 0);    chk("rst_tbl", dut4.tbl, 16'h1234);
    chk("rst_rdy2", rdy2, 0);   chk("rst_busy2", busy2, 0);
    rst = 1'b0;
    tick();

    // Test 1: single-minterm table, back-to-back sweep
    load4(p1, 0, 1, 0);
    chk("done_lat16", done4_cyc - ld_first, 16);
    for (int i = 0; i < 16; i++) exp4[i] = (i == 15);
    sweep4();

    // Test 2: equation table, expected values from the equation itself
    load4(p2, 0, 1, 0);
    for (int i = 0; i < 16; i++) exp4[i] = eqf(i[3:0]);
    sweep4();
    for (int i = 0; i < 8; i++) begin
      iv4   = 1'b1;
      addr4 = vt[i].addr;
      tick();
      iv4 = 1'b0;
      chk("vec_ov", ov4, 1);
      chk("vec_res", res4, vt[i].exp);
      tick();
    end

    // Test 3: K=2 instance; lookups ignored while unconfigured
    iv2 = 1'b1; addr2 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("uncfg_rdy2", rdy2, 0);
      chk("uncfg_ov2", ov2, 0);
    end
    iv2 = 1'b0;
    chk("uncfg_ov2_cnt", ov2_cnt, 0);
    c2_start = 1'b1; tick(); c2_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c2_valid = 1'b1; c2_bit = pk2[i]; tick();
    end
    c2_valid = 1'b0; tick();
    chk("done2_once", done2_cnt, 1);
    exp2 = 4'b1000;
    for (int a = 0; a < 4; a++) begin
      iv2 = 1'b1; addr2 = a[1:0]; tick();
      chk("sweep2_ov", ov2, 1);
    end
    iv2 = 1'b0; tick(); tick();
    chk("sweep2_cnt", ov2_cnt, 4);
    chk("sb2_empty", q2.size(), 0);

    // Test 4: stalled load, then restart after 7 bits
    load4(p4a, 1, 1, 0);
    chk("done_lat32", done4_cyc - ld_start, 32);
    exp4 = p4a;
    sweep4();
    n0 = done4_cnt;
    c4_start = 1'b1; tick(); c4_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      c4_valid = 1'b1; c4_bit = ~p4b[i]; tick();
    end
    c4_start = 1'b1; c4_valid = 1'b1; c4_bit = ~p4b[0];
    tick();
    c4_start = 1'b0; c4_valid = 1'b0;
    chk("restart_busy", busy4, 1);
    chk("restart_nodone", done4_cnt - n0, 0);
    load4(p4b, 0, 0, 0);
    exp4 = p4b;
    sweep4();

    // Test 5: reset at bit 9 aborts the load and restores INIT
    n0 = done4_cnt;
    c4_start = 1'b1; tick(); c4_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      c4_valid = 1'b1; c4_bit = p5[i]; tick();
    end
    rst = 1'b1; c4_valid = 1'b1; c4_bit = p5[9];
    tick();
    rst = 1'b0; c4_valid = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_rdy", rdy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_tbl", dut4.tbl, 16'h1234);
    tick();
    chk("abort_nodone", done4_cnt - n0, 0);
    load4(p5, 0, 1, 0);
    exp4 = p5;
    sweep4();

    // Test 6: lookup coincident with cfg_start sees the old table
    n0 = ov4_cnt;
    c4_start = 1'b1; iv4 = 1'b1; addr4 = 4'd0;
    tick();
    c4_start = 1'b0;
    chk("samecyc_ov", ov4, 1);
    chk("samecyc_res", res4, 1);
    chk("samecyc_rdy", rdy4, 0);
    chk("samecyc_busy", busy4, 1);
    load4(p6, 0, 0, 1);
    chk("samecyc_ov_cnt", ov4_cnt - n0, 1);
    exp4 = p6;
    sweep4();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_lut_k.md
Name: cfg_lut_k

Overview:
Generic K-input look-up table with a serially programmed truth table. It is the parametrised successor of the fixed and2/and4/equation LUTs: any K-input Boolean function is loaded at run time through a bit-serial configuration port. Lookups use a valid/ready handshake and return a registered result. It is the standard building block for programmable logic functions in the datapath.

Parameters:
K, 4, number of address inputs; the table depth is 2**K bits (legal range 1..8).
INIT, {2**K{1'b0}}, table contents loaded at reset; the block also starts in UNCFG, so INIT is for debug visibility only.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
cfg_start  in  1  begin (or restart) table load
cfg_valid  in  1  cfg_bit is valid this cycle
cfg_bit  in  1  serial table bit; LSB first (entry for address 0 first)
cfg_busy  out  1  high while in LOAD
cfg_done  out  1  one-cycle pulse when the load completes
in_valid  in  1  lookup request
in_ready  out  1  lookup can be accepted
address  in  K  lookup address; bit 0 = first variable (a)
out_valid  out  1  result valid, one-cycle pulse per accepted lookup
result  out  1  table[address] of the accepted request

Behaviour:
- Reset (rst=1 at posedge): state=UNCFG, table=INIT, cnt=0. All outputs read 0: cfg_busy, cfg_done, in_ready, out_valid, result. Reset has priority over every other input.
- States: UNCFG, LOAD, READY.
  - in_ready = (state==READY), decoded combinationally from the state register.
  - cfg_busy = (state==LOAD).
- UNCFG:
  - in_valid is ignored; out_valid stays 0.
  - cfg_start=1 -> LOAD, cnt=0.
- LOAD:
  - Each cycle with cfg_valid=1: table[cnt]<=cfg_bit, cnt<=cnt+1.
  - cfg_valid=0 stalls the load; no change to table or cnt.
  - cnt is K+1 bits wide. The load completes when the bit written has cnt==2**K-1: the next state is READY and cfg_done=1 for exactly the following cycle.
  - cfg_start=1 while in LOAD restarts the load: cnt=0, and any cfg_valid in the same cycle is ignored. Bits already written stay in the table until overwritten.
- READY:
  - When in_valid & in_ready, the next cycle gives out_valid=1 and result=table[address sampled at accept].
  - Latency is 1 cycle; back-to-back throughput is 1 lookup per cycle.
  - cfg_start=1 -> LOAD next cycle. A lookup accepted in the same cycle completes with the pre-load table. No lookups are accepted during LOAD.
- result holds its last value while out_valid=0.
- A reset in the middle of a load aborts it: state=UNCFG and the table returns to INIT. A pending out_valid is squashed.
- X on address with in_valid=1 is a bench error, not handled in RTL.

Decomposition:
- Package lut_pkg holds:
  - lut_state_t enum {UNCFG, LOAD, READY};
  - localparams for the depth function (2**K) and the count width (K+1).
- One sub-module, lut_cfg_loader, owns the state register, cnt, cfg_busy/cfg_done and the table write enable. The top level owns the table register, the read mux and the output register.

Test Plan:
1. K=4, load 16'h8000, then sweep addresses 0..15 back-to-back -> result=1 only for address 4'b1111; 16 out_valid pulses on consecutive cycles; cfg_done seen exactly once, 16 cycles after the first cfg_valid.
2. K=4, load 16'hDAA5, i.e. ((a&b&c&d)|(c^a)) XNOR d with a=bit0, d=bit3, then sweep 0..15 -> result matches the equation at all 16 addresses, e.g. addr0=1, addr1=0, addr9=1, addr13=0, addr15=1.
3. K=2 instance, load 4'b1000, sweep 0..3 -> result 0,0,0,1. Separately, in_valid=1 in UNCFG -> in_ready=0 and no out_valid.
4. Load with cfg_valid toggling 1/0 every cycle -> cfg_busy stays high throughout and cfg_done arrives 32 cycles after start. Then assert cfg_start mid-load, after 7 bits, and load the full new table -> the final table equals the new pattern.
5. Assert rst in the middle of a load at bit 9 -> next cycle state=UNCFG, cfg_busy=0, in_ready=0, table=INIT. A following full load works normally.
6. In READY, issue a lookup on the same cycle as cfg_start -> out_valid=1 next cycle with the old-table result; in_ready=0 until cfg_done.
